// File: rtl/sensor_responder.sv
// rtl/sensor_responder.sv - sensor-node command responder with debounced sticky alarm
// Optional feature macro: RESP_PARITY_EN (odd command parity in, even response parity out).
module sensor_responder #(
  parameter logic [3:0]  SENSOR_ID    = 4'h1,
  parameter logic [7:0]  SCRAMBLE_KEY = 8'h37,
  parameter int unsigned REPLY_DELAY  = 4,
  parameter int unsigned DEBOUNCE_LEN = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd,
  input  logic       cmd_valid,
`ifdef RESP_PARITY_EN
  input  logic       cmd_par,
  output logic       resp_par,
`endif
  input  logic       sensor_in,
  output logic [7:0] resp,
  output logic       resp_valid,
  output logic       busy,
  output logic [1:0] estado
);

  localparam logic [3:0] DELAY  = 4'(REPLY_DELAY);
  localparam logic [3:0] DB_LEN = 4'(DEBOUNCE_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WAIT   = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] cmd_q;
  logic [3:0] cnt;
  logic [7:0] payload;

  logic       sync1;
  logic       sync2;
  logic       live;
  logic       latched;
  logic       overrun;
  logic [3:0] db_cnt;

  logic       par_ok;
`ifdef RESP_PARITY_EN
  logic       par_q;
  // A good command carries an odd number of ones across {cmd, cmd_par}.
  assign par_ok = ^{cmd_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  logic id_ok;
  logic op_ok;
  logic decode_go;
  logic do_clear;
  logic do_poll;
  logic ovr_set;

  assign id_ok     = (cmd_q[7:4] == SENSOR_ID);
  assign op_ok     = (cmd_q[3:0] == 4'd1) || (cmd_q[3:0] == 4'd2) || (cmd_q[3:0] == 4'd3);
  assign decode_go = (state == DECODE) && par_ok && id_ok && op_ok;
  assign do_clear  = decode_go && (cmd_q[3:0] == 4'd3);
  assign do_poll   = decode_go && (cmd_q[3:0] == 4'd1);
  assign ovr_set   = (cmd_valid && (state != IDLE)) || ((state == DECODE) && !par_ok);

  assign busy   = (state != IDLE);
  assign estado = state;

  // live follows the synchronised line only after DB_LEN samples in a row disagree with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      live   <= 1'b0;
      db_cnt <= 4'd0;
    end else begin
      sync1 <= sensor_in;
      sync2 <= sync1;
      if (sync2 == live) begin
        db_cnt <= 4'd0;
      end else if (db_cnt + 4'd1 >= DB_LEN) begin
        live   <= sync2;
        db_cnt <= 4'd0;
      end else begin
        db_cnt <= db_cnt + 4'd1;
      end
    end
  end

  // Overrun is reported once by the POLL that snapshots it; a new set in the same cycle wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      latched <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (live) latched <= 1'b1;
      else if (do_clear) latched <= 1'b0;
      if (ovr_set) overrun <= 1'b1;
      else if (do_poll) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_q      <= 8'h00;
      cnt        <= 4'd0;
      payload    <= 8'h00;
      resp       <= 8'h00;
      resp_valid <= 1'b0;
`ifdef RESP_PARITY_EN
      par_q      <= 1'b0;
      resp_par   <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q <= cmd;
`ifdef RESP_PARITY_EN
            par_q <= cmd_par;
`endif
            state <= DECODE;
          end
        end
        DECODE: begin
          if (decode_go) begin
            case (cmd_q[3:0])
              4'd1:    payload <= {SENSOR_ID, overrun, 1'b0, latched, live};
              4'd2:    payload <= {SENSOR_ID, 4'hA};
              default: payload <= {SENSOR_ID, 4'h5};
            endcase
            cnt   <= DELAY;
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            resp       <= payload ^ SCRAMBLE_KEY;
            resp_valid <= 1'b1;
`ifdef RESP_PARITY_EN
            resp_par   <= ^(payload ^ SCRAMBLE_KEY);
`endif
            state      <= SEND;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SEND:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_responder.sv
// tb/tb_sensor_responder.sv - scoreboard bench for sensor_responder with a timing-level reference model
module tb_sensor_responder;

  localparam int         D   = 4;
  localparam int         LEN = 3;
  localparam logic [3:0] ID  = 4'h1;
  localparam logic [7:0] KEY = 8'h37;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cmd = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       sensor_in = 1'b0;
  logic [7:0] resp;
  logic       resp_valid;
  logic       busy;
  logic [1:0] estado;
`ifdef RESP_PARITY_EN
  logic       cmd_par = 1'b0;
  logic       resp_par;
`endif

  sensor_responder #(
    .SENSOR_ID(ID), .SCRAMBLE_KEY(KEY), .REPLY_DELAY(D), .DEBOUNCE_LEN(LEN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
`ifdef RESP_PARITY_EN
    .cmd_par(cmd_par),
    .resp_par(resp_par),
`endif
    .sensor_in(sensor_in),
    .resp(resp),
    .resp_valid(resp_valid),
    .busy(busy),
    .estado(estado)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    int         due;
  } exp_t;
  exp_t exp_q[$];

  // Model state: time-based view of the transaction plus sensor history window.
  int         cyc = 0;
  int         acc = -1000;
  int         done = -1000;
  logic [7:0] acc_cmd = 8'h00;
  bit         acc_par_ok = 1'b1;
  bit         m_live, m_latched, m_ovr;
  bit         hist[$];
  bit         new_live, set_o, clr_o, clr_l, agree;
  logic [7:0] pay;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_live = 0; m_latched = 0; m_ovr = 0;
      acc = -1000; done = -1000;
      hist.delete();
      for (int i = 0; i < LEN + 2; i++) hist.push_back(1'b0);
    end else begin
      cyc++;
      hist.push_front(sensor_in);
      set_o = 0; clr_o = 0; clr_l = 0;
      if (cyc == acc + 1) begin
        if (!acc_par_ok) begin
          set_o = 1;
          done = acc + 1;
        end else if (acc_cmd[7:4] == ID && acc_cmd[3:0] >= 4'd1 && acc_cmd[3:0] <= 4'd3) begin
          case (acc_cmd[3:0])
            4'd1: begin pay = {ID, m_ovr, 1'b0, m_latched, m_live}; clr_o = 1; end
            4'd2: pay = {ID, 4'hA};
            default: begin pay = {ID, 4'h5}; clr_l = 1; end
          endcase
          exp_q.push_back('{b: pay ^ KEY, due: acc + 2 + D});
        end else begin
          done = acc + 1;
        end
      end
      if (cmd_valid) begin
        if (cyc > acc && cyc <= done) set_o = 1;
        else begin
          acc = cyc; done = cyc + 3 + D; acc_cmd = cmd;
`ifdef RESP_PARITY_EN
          acc_par_ok = (^{cmd, cmd_par}) == 1'b1;
`else
          acc_par_ok = 1'b1;
`endif
        end
      end
      agree = 1;
      for (int i = 3; i <= LEN + 1; i++) if (hist[i] != hist[2]) agree = 0;
      new_live = (agree && hist[2] != m_live) ? hist[2] : m_live;
      m_latched = m_live ? 1'b1 : (clr_l ? 1'b0 : m_latched);
      m_ovr = set_o ? 1'b1 : (clr_o ? 1'b0 : m_ovr);
      m_live = new_live;
      void'(hist.pop_back());
    end
  end

  int         rd = 0;
  logic [7:0] hold = 8'h00;
  int         off;
  logic       busy_e;
  logic [1:0] st_e;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      rd = exp_q.size();
      hold = 8'h00;
      chk("rst_resp", resp, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_estado", estado, 0);
    end else begin
      if (cyc >= acc && cyc < done) begin
        off = cyc - acc;
        busy_e = 1;
        st_e = (off == 0) ? 2'd1 : ((off <= 1 + D) ? 2'd2 : 2'd3);
      end else begin
        busy_e = 0;
        st_e = 2'd0;
      end
      chk("busy", busy, busy_e);
      chk("estado", estado, st_e);
      if (rd < exp_q.size() && exp_q[rd].due < cyc) begin
        chk("missing_resp_valid", 0, 1);
        rd++;
      end
      if (resp_valid) begin
        if (rd < exp_q.size()) begin
          chk("resp", resp, exp_q[rd].b);
          chk("resp_cycle", cyc, exp_q[rd].due);
          hold = exp_q[rd].b;
          rd++;
        end else begin
          chk("spurious_resp_valid", resp_valid, 0);
        end
      end else begin
        chk("resp_hold", resp, hold);
      end
    end
`ifdef RESP_PARITY_EN
    chk("resp_par", resp_par, ^hold);
`endif
  end

  task automatic pulse(input logic [7:0] c, input bit bad_par);
    cmd = c;
    cmd_valid = 1'b1;
`ifdef RESP_PARITY_EN
    cmd_par = bad_par ? ^c : ~^c;
`endif
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd = 8'($urandom);
  endtask

  task automatic directed(input string name, input logic [7:0] c, input bit bad_par,
                          input bit want, input logic [7:0] want_b);
    int seen_at;
    int count;
    logic [7:0] got;
    seen_at = -1; count = 0; got = 8'h00;
    pulse(c, bad_par);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        count++;
        if (seen_at < 0) begin seen_at = k; got = resp; end
      end
    end
    chk({name, "_strobes"}, count, want ? 1 : 0);
    if (want) begin
      chk({name, "_byte"}, got, want_b);
      chk({name, "_latency"}, seen_at, 2 + D);
    end
  endtask

  int n_resp;

  initial begin
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);

    directed("poll_idle", 8'h11, 0, 1, 8'h27);
    sensor_in = 1'b1;
    repeat (10) @(negedge clock);
    directed("poll_live", 8'h11, 0, 1, 8'h24);
    sensor_in = 1'b0;
    repeat (10) @(negedge clock);
    directed("poll_latched", 8'h11, 0, 1, 8'h25);
    directed("clear", 8'h13, 0, 1, 8'h22);
    directed("poll_cleared", 8'h11, 0, 1, 8'h27);
    directed("ping", 8'h12, 0, 1, 8'h2D);
    directed("other_id", 8'h21, 0, 0, 8'h00);
    directed("bad_opcode", 8'h1F, 0, 0, 8'h00);

    // Second command two cycles into a POLL is dropped and flags overrun.
    n_resp = 0;
    pulse(8'h11, 0);
    cmd = 8'h11; cmd_valid = 1'b1;
`ifdef RESP_PARITY_EN
    cmd_par = 1'b1;
`endif
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      if (resp_valid) n_resp++;
    end
    chk("overrun_single_resp", n_resp, 1);
    directed("poll_overrun", 8'h11, 0, 1, 8'h2F);
    directed("poll_after_overrun", 8'h11, 0, 1, 8'h27);

    sensor_in = 1'b1;
    repeat (2) @(negedge clock);
    sensor_in = 1'b0;
    repeat (6) @(negedge clock);
    directed("poll_glitch", 8'h11, 0, 1, 8'h27);

`ifdef RESP_PARITY_EN
    directed("par_good", 8'h11, 0, 1, 8'h27);
    chk("par_good_resp_par", resp_par, 0);
    directed("par_bad", 8'h11, 1, 0, 8'h00);
    directed("poll_after_par_bad", 8'h11, 0, 1, 8'h2F);
`endif

    // Reset while the response is pending must abort it silently.
    n_resp = 0;
    pulse(8'h11, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("abort_resp", resp, 0);
    chk("abort_busy", busy, 0);
    chk("abort_estado", estado, 0);
    #2 reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (resp_valid) n_resp++;
    end
    chk("abort_no_strobe", n_resp, 0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) sensor_in = ~sensor_in;
      if ($urandom_range(0, 999) == 0) begin
        cmd_valid = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
      end
      cmd_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 7))
        0: cmd = 8'h11;
        1: cmd = 8'h12;
        2: cmd = 8'h13;
        3: cmd = 8'h1F;
        4: cmd = 8'h21;
        5: cmd = 8'h11;
        6: cmd = 8'h10;
        default: cmd = 8'($urandom);
      endcase
`ifdef RESP_PARITY_EN
      cmd_par = ($urandom_range(0, 7) == 0) ? ^cmd : ~^cmd;
`endif
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    repeat (20) @(negedge clock);
    chk("drain_pending", exp_q.size() - rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
